draw_sprite_anim: RTL and testbench

- Parametrised, pipelined sprite overlay for the player character.
- Sits in the vga_if chain after the background/rect stages.
- Overlays an animated, direction-dependent sprite read from an external synchronous ROM onto the incoming pixel stream.
- Adds background pass-through, transparency keying, frame-locked position/state latching and a walk-cycle animation counter.

---
 rtl/draw_sprite_anim.sv | 234 +++++++++++++++++++++++
 tb/tb_draw_sprite_anim.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sprite_anim.sv
// ============================================================================
// Module   : draw_sprite_anim (with state_pkg and vga_if)
// Brief    : Pipelined animated player-sprite overlay on the vga_if stream.
//            Optional macro DRAW_SPRITE_MIRROR_EN: LEFT mirrors the RIGHT bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package state_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2
    } State;
endpackage

interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

module draw_sprite_anim
    import state_pkg::*;
#(
    parameter int          SPRITE_W    = 64,
    parameter int          SPRITE_H    = 64,
    parameter int          FRAMES      = 4,
    parameter int          FRAME_DIV   = 8,
    parameter int          ROM_LATENCY = 1,
    parameter logic [11:0] TRANSPARENT = 12'hF0F,
    localparam int c_XB     = $clog2(SPRITE_W),
    localparam int c_YB     = $clog2(SPRITE_H),
    localparam int c_FB     = $clog2(FRAMES),
    localparam int c_FW     = (c_FB > 0) ? c_FB : 1,
    localparam int c_ADDR_W = 2 + c_FB + c_YB + c_XB
) (
    input  logic                clk,
    input  logic                rst,
    vga_if.in                   vga_in,
    vga_if.out                  vga_out,
    input  logic [11:0]         player_xpos,
    input  logic [11:0]         player_ypos,
    input  State                state,
    output logic [c_ADDR_W-1:0] rom_addr,
    input  logic [11:0]         rom_data,
    output logic [c_FW-1:0]     frame_idx
);

    localparam logic [7:0]      c_DIV_LAST   = 8'(FRAME_DIV - 1);
    localparam logic [c_FW-1:0] c_FRAME_LAST = c_FW'(FRAMES - 1);

    typedef enum logic [0:0] {
        IDLE_ST = 1'b0,
        WALK_ST = 1'b1
    } anim_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_box;
    } pix_t;

    anim_t           r_anim, w_anim_nxt;
    logic [c_FW-1:0] r_frame, w_frame_nxt;
    logic [7:0]      r_div, w_div_nxt;
    logic            r_vsync_d;
    logic            r_armed;
    logic [11:0]     r_xs, r_ys;
    State            r_st;
    State            w_st_in;
    logic            w_tick;

    // r_armed suppresses a spurious tick when vsync is already high out of reset
    assign w_tick  = r_armed & vga_in.vsync & ~r_vsync_d;
    assign w_st_in = (state == RIGHT || state == LEFT) ? state : IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
            r_armed   <= 1'b0;
            r_xs      <= '0;
            r_ys      <= '0;
            r_st      <= IDLE;
            r_anim    <= IDLE_ST;
            r_frame   <= '0;
            r_div     <= '0;
        end else begin
            r_vsync_d <= vga_in.vsync;
            r_armed   <= 1'b1;
            if (w_tick) begin
                r_xs <= player_xpos;
                r_ys <= player_ypos;
                r_st <= w_st_in;
            end
            r_anim  <= w_anim_nxt;
            r_frame <= w_frame_nxt;
            r_div   <= w_div_nxt;
        end
    end

    always_comb begin
        w_anim_nxt  = r_anim;
        w_frame_nxt = r_frame;
        w_div_nxt   = r_div;
        if (w_tick) begin
            if (w_st_in == IDLE) begin
                w_anim_nxt  = IDLE_ST;
                w_frame_nxt = '0;
                w_div_nxt   = '0;
            end else if (r_anim == IDLE_ST || w_st_in != r_st) begin
                w_anim_nxt  = WALK_ST;
                w_frame_nxt = '0;
                w_div_nxt   = '0;
            end else if (r_div == c_DIV_LAST) begin
                w_div_nxt   = '0;
                w_frame_nxt = (r_frame == c_FRAME_LAST) ? '0 : r_frame + 1'b1;
            end else begin
                w_div_nxt   = r_div + 8'd1;
            end
        end
    end

    // 13-bit compare keeps xs/ys near 4095 from wrapping back onto the screen
    logic [12:0]         w_hc13, w_vc13, w_xs13, w_ys13;
    logic                w_in_box;
    logic [c_XB-1:0]     w_dx, w_xoff;
    logic [c_YB-1:0]     w_dy;
    logic [1:0]          w_bank;
    logic [c_ADDR_W-1:0] w_addr;

    assign w_hc13   = {2'b00, vga_in.hcount};
    assign w_vc13   = {2'b00, vga_in.vcount};
    assign w_xs13   = {1'b0, r_xs};
    assign w_ys13   = {1'b0, r_ys};
    assign w_in_box = (w_hc13 >= w_xs13) && (w_hc13 < w_xs13 + 13'(SPRITE_W)) &&
                      (w_vc13 >= w_ys13) && (w_vc13 < w_ys13 + 13'(SPRITE_H));
    assign w_dx     = vga_in.hcount[c_XB-1:0] - r_xs[c_XB-1:0];
    assign w_dy     = vga_in.vcount[c_YB-1:0] - r_ys[c_YB-1:0];

`ifdef DRAW_SPRITE_MIRROR_EN
    localparam logic [c_XB-1:0] c_XOFF_MAX = c_XB'(SPRITE_W - 1);
`endif

    always_comb begin
        w_bank = 2'd0;
        w_xoff = w_dx;
        case (r_st)
            RIGHT: w_bank = 2'd1;
            LEFT: begin
`ifdef DRAW_SPRITE_MIRROR_EN
                w_bank = 2'd1;
                w_xoff = c_XOFF_MAX - w_dx;
`else
                w_bank = 2'd2;
`endif
            end
            default: w_bank = 2'd0;
        endcase
    end

    generate
        if (c_FB > 0) begin : g_addr_frame
            assign w_addr = {w_bank, r_frame, w_dy, w_xoff};
        end else begin : g_addr_single
            assign w_addr = {w_bank, w_dy, w_xoff};
        end
    endgenerate

    // r_pipe[0] is stage 1; the last entry lines up with rom_data
    pix_t                r_pipe [0:ROM_LATENCY];
    logic [c_ADDR_W-1:0] r_rom_addr;
    pix_t                w_s0, w_d;

    assign w_s0 = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                    hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                    hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk,
                    rgb:    vga_in.rgb,    in_box: w_in_box};
    assign w_d  = r_pipe[ROM_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ROM_LATENCY; i++) r_pipe[i] <= '0;
            r_rom_addr <= '0;
        end else begin
            r_pipe[0] <= w_s0;
            for (int i = 1; i <= ROM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
            r_rom_addr <= w_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= w_d.hcount;
            vga_out.vcount <= w_d.vcount;
            vga_out.hsync  <= w_d.hsync;
            vga_out.vsync  <= w_d.vsync;
            vga_out.hblnk  <= w_d.hblnk;
            vga_out.vblnk  <= w_d.vblnk;
            if (w_d.hblnk || w_d.vblnk)
                vga_out.rgb <= '0;
            else if (w_d.in_box && rom_data != TRANSPARENT)
                vga_out.rgb <= rom_data;
            else
                vga_out.rgb <= w_d.rgb;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign frame_idx = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_draw_sprite_anim.sv
// ============================================================================
// Module   : tb_draw_sprite_anim
// Brief    : Directed bench for draw_sprite_anim with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_sprite_anim;
    import state_pkg::*;

    localparam int          W  = 64;
    localparam int          H  = 64;
    localparam int          FR = 4;
    localparam int          FD = 8;
    localparam logic [11:0] TR = 12'hF0F;
`ifdef DRAW_SPRITE_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] px, py;
    State        st;
    logic [15:0] rom_addr;
    logic [11:0] rom_data;
    logic [1:0]  frame_idx;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    vga_if vin ();
    vga_if vout ();

    draw_sprite_anim #(
        .SPRITE_W(W), .SPRITE_H(H), .FRAMES(FR), .FRAME_DIV(FD),
        .ROM_LATENCY(1), .TRANSPARENT(TR)
    ) dut (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vout),
        .player_xpos(px), .player_ypos(py), .state(st),
        .rom_addr(rom_addr), .rom_data(rom_data), .frame_idx(frame_idx)
    );

    // Sprite art: bank 0 solid cyan; other banks keyed transparent on the first 8 columns
    function automatic logic [11:0] rom_f(input logic [15:0] a);
        if (a[15:14] == 2'd0) return 12'h0FF;
        if (a[5:0] < 6'd8)    return TR;
        return {a[15:12], 2'b00, a[5:0]};
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    // Reference model: screen-level rules with a 3-deep expected-output queue
    bit          m_valid = 1'b0;
    logic        m_vs_d;
    bit          m_armed;
    int          m_xs, m_ys, m_frame, m_div;
    State        m_st;
    bit          m_walk;
    out_t        q0, q1, q2;
    logic [15:0] m_addr;

    always @(posedge clk) begin : model
        int hc, vc, dx, dy, xo, bank;
        bit inb;
        logic [15:0] a;
        logic [11:0] d;
        out_t n;
        State sn;
        if (rst) begin
            m_valid = 1'b1; m_vs_d = 1'b0; m_armed = 1'b0;
            m_xs = 0; m_ys = 0; m_st = IDLE; m_walk = 1'b0; m_frame = 0; m_div = 0;
            q0 = '0; q1 = '0; q2 = '0; m_addr = '0;
        end else begin
            hc  = int'(vin.hcount);
            vc  = int'(vin.vcount);
            inb = (hc >= m_xs) && (hc < m_xs + W) && (vc >= m_ys) && (vc < m_ys + H);
            dx  = (hc - m_xs) & (W - 1);
            dy  = (vc - m_ys) & (H - 1);
            bank = (m_st == RIGHT) ? 1 : (m_st == LEFT) ? (MIRROR ? 1 : 2) : 0;
            xo   = (MIRROR && m_st == LEFT) ? (W - 1 - dx) : dx;
            a    = 16'(bank * 16384 + m_frame * 4096 + dy * 64 + xo);
            d    = rom_f(a);
            n.hc = vin.hcount; n.vc = vin.vcount; n.hs = vin.hsync; n.vs = vin.vsync;
            n.hb = vin.hblnk;  n.vb = vin.vblnk;
            n.rgb = (vin.hblnk || vin.vblnk) ? 12'h000 : (inb && d != TR) ? d : vin.rgb;
            q2 = q1; q1 = q0; q0 = n; m_addr = a;
            if (m_armed && vin.vsync && !m_vs_d) begin
                sn = (st == RIGHT || st == LEFT) ? st : IDLE;
                if (sn == IDLE) begin
                    m_walk = 1'b0; m_frame = 0; m_div = 0;
                end else if (!m_walk || sn != m_st) begin
                    m_walk = 1'b1; m_frame = 0; m_div = 0;
                end else if (m_div == FD - 1) begin
                    m_div = 0; m_frame = (m_frame + 1) % FR;
                end else begin
                    m_div = m_div + 1;
                end
                m_st = sn; m_xs = int'(px); m_ys = int'(py);
            end
            m_vs_d = vin.vsync; m_armed = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: inputs change at the falling edge, outputs are checked at the next one
    task automatic step(input int hc, input int vc, input logic [11:0] rgb,
                        input bit hb, input bit vb, input bit vs);
        vin.hcount = 11'(hc); vin.vcount = 11'(vc); vin.rgb = rgb;
        vin.hblnk = hb; vin.vblnk = vb; vin.hsync = hb; vin.vsync = vs;
        @(negedge clk);
        if (m_valid) begin
            chk("vga_out", 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                                vout.hblnk, vout.vblnk, vout.rgb}), 64'(q2));
            chk("frame_idx", 64'(frame_idx), 64'(m_frame));
            chk("rom_addr", 64'(rom_addr), 64'(m_addr));
        end
    endtask

    task automatic pix(input int hc, input int vc);
        step(hc, vc, 12'h123, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic probe(input string name, input int hc, input int vc, input logic [11:0] exp);
        pix(hc, vc); pix(hc + 1, vc); pix(hc + 2, vc);
        chk(name, 64'(vout.rgb), 64'(exp));
    endtask

    task automatic tick();
        step(0, 0, 12'h000, 1'b1, 1'b1, 1'b1);
        step(0, 0, 12'h000, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 12'h000, 1'b1, 1'b1, 1'b0);
        step(0, 0, 12'h000, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        step(0, 0, 12'h000, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic scan(input int vc, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) pix(h, vc);
    endtask

    initial begin
        rst = 1'b1; px = 12'd100; py = 12'd200; st = RIGHT;
        step(0, 0, 12'h000, 1'b1, 1'b1, 1'b0);
        step(0, 0, 12'h000, 1'b1, 1'b1, 1'b0);
        chk("reset_rgb", 64'(vout.rgb), 64'h0);
        chk("reset_frame", 64'(frame_idx), 64'h0);
        rst = 1'b0;

        // vsync high in the first cycle after reset must not latch RIGHT
        step(0, 0, 12'h000, 1'b1, 1'b1, 1'b1);
        step(0, 0, 12'h000, 1'b1, 1'b1, 1'b1);
        pix(10, 10);
        chk("no_first_tick_bank", 64'(rom_addr[15:14]), 64'd0);

        st = IDLE; tick();
        probe("idle_in_tl", 100, 200, 12'h0FF);
        probe("idle_left_of_box", 97, 200, 12'h123);
        probe("idle_in_br", 161, 263, 12'h0FF);
        probe("idle_right_of_box", 164, 200, 12'h123);
        probe("idle_above_box", 100, 199, 12'h123);
        probe("idle_below_box", 100, 264, 12'h123);
        step(120, 210, 12'h123, 1'b1, 1'b0, 1'b0); pix(121, 210); pix(122, 210);
        chk("blank_in_box", 64'(vout.rgb), 64'h0);
        scan(199, 90, 170); scan(200, 90, 170); scan(263, 90, 170); scan(264, 90, 170);

        st = State'(2'b11); tick();
        probe("undef_state_idle", 100, 200, 12'h0FF);

        st = RIGHT; tick();
        probe("transparent_col3", 103, 200, 12'h123);
        probe("opaque_col8", 108, 200, 12'h408);
        scan(210, 95, 170);

        px = 12'd300;
        probe("latched_old_x", 120, 200, 12'h414);
        probe("latched_not_new_x", 320, 200, 12'h123);
        tick();
        probe("moved_new_x", 320, 200, 12'h414);
        probe("moved_old_x", 120, 200, 12'h123);

        px = 12'd4090; tick();
        probe("clip_hc0", 0, 200, 12'h123);
        probe("clip_hc55", 55, 200, 12'h123);
        scan(200, 0, 70);

        px = 12'd100; st = LEFT; tick();
        pix(100, 200);
        chk("left_bank", 64'(rom_addr[15:14]), MIRROR ? 64'd1 : 64'd2);
        chk("left_xoff", 64'(rom_addr[5:0]), MIRROR ? 64'd63 : 64'd0);
        scan(220, 95, 170);

        do_reset(); st = RIGHT;
        for (int k = 0; k <= 32; k++) begin
            tick();
            if (k == 7)  chk("walk_t7", 64'(frame_idx), 64'd0);
            if (k == 8)  chk("walk_t8", 64'(frame_idx), 64'd1);
            if (k == 16) chk("walk_t16", 64'(frame_idx), 64'd2);
            if (k == 24) chk("walk_t24", 64'(frame_idx), 64'd3);
            if (k == 32) chk("walk_t32", 64'(frame_idx), 64'd0);
        end

        do_reset();
        for (int k = 0; k <= 28; k++) begin
            st = (k >= 20) ? LEFT : RIGHT;
            tick();
            if (k == 19) chk("dir_t19", 64'(frame_idx), 64'd2);
            if (k == 20) chk("dir_t20", 64'(frame_idx), 64'd0);
            if (k == 27) chk("dir_t27", 64'(frame_idx), 64'd0);
            if (k == 28) chk("dir_t28", 64'(frame_idx), 64'd1);
        end

        st = IDLE; tick();
        scan(205, 98, 130);
        rst = 1'b1;
        pix(131, 205);
        chk("midreset_hcount", 64'(vout.hcount), 64'd0);
        chk("midreset_rgb", 64'(vout.rgb), 64'd0);
        chk("midreset_frame", 64'(frame_idx), 64'd0);
        rst = 1'b0;
        pix(500, 5);
        chk("refill_black", 64'(vout.rgb), 64'd0);
        pix(501, 5); pix(502, 5);
        chk("refill_hcount", 64'(vout.hcount), 64'd500);
        scan(5, 503, 520);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
